noc_rr_arb_mux: RTL and testbench

Parametrised N-input to 1-output NoC output-port stage: round-robin arbitration across N flit channels, one-hot grant mux, and a one-entry registered output with valid/ready handshake. It replaces the fixed one-hot case-select function (capped at 16 inputs, no arbitration) as the per-output-port switch stage of the router. With packet lock compiled in, a grant holds from the head flit to the tail flit, giving wormhole switching.

---
 rtl/noc_rr_arb_mux.sv | 123 ++++++++++++
 tb/tb_noc_rr_arb_mux.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_arb_mux.sv
// noc_rr_arb_mux: N-to-1 round-robin arbiter, one-hot AND-OR mux and one-entry output register (1-cycle latency).
// Inputs stall (in_ready=0) while an unaccepted flit is held; NOC_ARB_PKT_LOCK_EN holds the grant head-to-tail.
module noc_rr_arb_mux #(
  parameter int N         = 5,
  parameter int DataWidth = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                in_valid,
  input  logic [N-1:0][DataWidth-1:0] in_data,
  input  logic [N-1:0]                in_last,
  output logic [N-1:0]                in_ready,
  output logic                        out_valid,
  output logic [DataWidth-1:0]        out_data,
  output logic                        out_last,
  output logic [N-1:0]                out_src,
  input  logic                        out_ready
);
  localparam int PtrW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

  logic [PtrW-1:0]      ptr;
  logic [PtrW-1:0]      ptr_next;
  logic [PtrW-1:0]      grant_idx;
  logic [N-1:0]         arb_grant;
  logic [N-1:0]         grant;
  logic                 arb_found;
  logic                 load_ok;
  logic                 in_hs;
  logic [DataWidth-1:0] mux_data;
  logic                 mux_last;

  assign load_ok = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {N{load_ok}});
  assign in_hs = |(in_valid & in_ready);

  // Two-pass scan: channels at or above ptr first, then the wrapped-around ones below it.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!arb_found && in_valid[i] && (PtrW'(i) >= ptr)) begin
        arb_grant[i] = 1'b1;
        arb_found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!arb_found && in_valid[i] && (PtrW'(i) < ptr)) begin
        arb_grant[i] = 1'b1;
        arb_found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    mux_data  = '0;
    mux_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PtrW'(i);
      mux_data = mux_data | (in_data[i] & {DataWidth{grant[i]}});
      mux_last = mux_last | (in_last[i] & grant[i]);
    end
  end

  assign ptr_next = (grant_idx == LastIdx) ? '0 : (grant_idx + PtrW'(1));

`ifdef NOC_ARB_PKT_LOCK_EN
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]   state;
  logic [N-1:0] lock;

  // While LOCKED the grant is pinned even if the locked channel is momentarily idle.
  assign grant = (state == LOCKED) ? lock : arb_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lock  <= '0;
      ptr   <= '0;
    end else if (in_hs) begin
      if (state == IDLE) begin
        ptr <= ptr_next;
        if (!mux_last) begin
          state <= LOCKED;
          lock  <= grant;
        end
      end else if (mux_last) begin
        state <= IDLE;
      end
    end
  end
`else
  assign grant = arb_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (in_hs) begin
      ptr <= ptr_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= mux_last;
      out_src   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_rr_arb_mux.sv
// Bench for noc_rr_arb_mux: N=4 and N=1 instances, scoreboard of expected output flits.
module tb_noc_rr_arb_mux;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         in_valid, in_last, in_ready, out_src;
  logic [N-1:0][DW-1:0] in_data;
  logic                 out_valid, out_last, out_ready;
  logic [DW-1:0]        out_data;

  logic [0:0]           s_in_valid, s_in_last, s_in_ready, s_out_src;
  logic [0:0][DW-1:0]   s_in_data;
  logic                 s_out_valid, s_out_last, s_out_ready;
  logic [DW-1:0]        s_out_data;

  typedef struct packed { logic [DW-1:0] data; logic last; logic [3:0] gap; } flit_t;
  typedef struct packed { logic [N-1:0] src; logic [DW-1:0] data; logic last; } exp_t;

  flit_t chq [N][$];
  int    gap_cnt [N];
  exp_t  sb [$];
  exp_t  sb1 [$];
  flit_t s_q [$];
  int    checks = 0;
  int    errors = 0;

  noc_rr_arb_mux #(.N(N), .DataWidth(DW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  noc_rr_arb_mux #(.N(1), .DataWidth(DW)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_src(s_out_src),
    .out_ready(s_out_ready)
  );

  // Scoreboard monitors: each output handshake pops one expected flit.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      checks++;
      if (!$onehot0(in_ready)) begin
        errors++;
        $display("FAIL in_ready_onehot: in_ready=%b, required at most one bit set", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: data=%h src=%b appeared, required no flit", out_data, out_src);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_last !== e.last || out_src !== e.src) begin
            errors++;
            $display("FAIL sb_flit: got data=%h last=%b src=%b, required data=%h last=%b src=%b",
                     out_data, out_last, out_src, e.data, e.last, e.src);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && s_out_valid && s_out_ready) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: data=%h appeared, required no flit", s_out_data);
      end else begin
        e = sb1.pop_front();
        if (s_out_data !== e.data || s_out_last !== e.last || s_out_src !== 1'b1) begin
          errors++;
          $display("FAIL sb1_flit: got data=%h last=%b src=%b, required data=%h last=%b src=1",
                   s_out_data, s_out_last, s_out_src, e.data, e.last);
        end
      end
    end
  end

  task automatic add_flit(input int ch, input logic [DW-1:0] d, input logic l, input int gap);
    flit_t f;
    f.data = d; f.last = l; f.gap = 4'(gap);
    chq[ch].push_back(f);
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.src = '0; e.src[ch] = 1'b1; e.data = d; e.last = l;
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() > 0 && gap_cnt[i] == 0) begin
        in_valid[i] = 1'b1; in_data[i] = chq[i][0].data; in_last[i] = chq[i][0].last;
      end else begin
        in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    acc = in_valid & in_ready;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (gap_cnt[i] > 0) gap_cnt[i]--;
      if (acc[i]) begin
        gap_cnt[i] = int'(chq[i][0].gap);
        void'(chq[i].pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int budget, output int cycles);
    logic busy;
    cycles = 0;
    busy = 1'b1;
    while (busy && cycles < budget) begin
      drive();
      #1;
      tick();
      cycles++;
      busy = (sb.size() > 0);
      for (int i = 0; i < N; i++) if (chq[i].size() > 0) busy = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    s_in_valid = '0; s_in_data = '0; s_in_last = '0; s_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin chq[i].delete(); gap_cnt[i] = 0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = '1; in_last = '1;
    for (int i = 0; i < N; i++) in_data[i] = 32'hC0 + i;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_src !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b src=%b, required all 0",
               out_valid, out_data, out_last, out_src);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, required 0000", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: in_ready=%b, required 0001", in_ready);
    end
    in_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int cycles;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        add_flit(i, 32'hA0 + i, 1'b1, 0);
        push_exp(i, 32'hA0 + i, 1'b1);
      end
    run(200, cycles);
    checks++;
    if (sb.size() != 0 || cycles != 9) begin
      errors++;
      $display("FAIL fairness_drain: cycles=%0d left=%0d, required cycles=9 left=0", cycles, sb.size());
    end
  endtask

  task automatic test_packet_lock();
    int cycles;
    do_reset();
    add_flit(2, 32'h20, 1'b0, 0);
    add_flit(2, 32'h21, 1'b0, 2);
    add_flit(2, 32'h22, 1'b1, 0);
    for (int k = 0; k < 3; k++) add_flit(1, 32'h10 + k, 1'b1, 0);
    gap_cnt[1] = 1;
`ifdef NOC_ARB_PKT_LOCK_EN
    push_exp(2, 32'h20, 1'b0); push_exp(2, 32'h21, 1'b0); push_exp(2, 32'h22, 1'b1);
    push_exp(1, 32'h10, 1'b1); push_exp(1, 32'h11, 1'b1); push_exp(1, 32'h12, 1'b1);
`else
    push_exp(2, 32'h20, 1'b0); push_exp(1, 32'h10, 1'b1); push_exp(2, 32'h21, 1'b0);
    push_exp(1, 32'h11, 1'b1); push_exp(1, 32'h12, 1'b1); push_exp(2, 32'h22, 1'b1);
`endif
    run(200, cycles);
    checks++;
    if (sb.size() != 0 || cycles >= 200) begin
      errors++;
      $display("FAIL packet_drain: cycles=%0d left=%0d, required all flits delivered", cycles, sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    add_flit(0, 32'hDEADBEEF, 1'b1, 0); push_exp(0, 32'hDEADBEEF, 1'b1);
    add_flit(1, 32'h11111111, 1'b1, 0); push_exp(1, 32'h11111111, 1'b1);
    drive(); #1; tick();
    for (int c = 0; c < 5; c++) begin
      drive(); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d valid=%b data=%h in_ready=%b, required 1 deadbeef 0000",
                 c, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    drive(); #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, required 0010", in_ready);
    end
    tick();
    drive(); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11111111) begin
      errors++;
      $display("FAIL bp_next_flit: valid=%b data=%h, required 1 11111111", out_valid, out_data);
    end
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: left=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int cycles;
    do_reset();
    out_ready = 1'b0;
    add_flit(2, 32'h77, 1'b0, 0);
    drive(); #1; tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_held: valid=%b src=%b, required 1 0100", out_valid, out_src);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || in_ready !== '0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b data=%h src=%b in_ready=%b, required all 0",
               out_valid, out_data, out_src, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    add_flit(1, 32'h31, 1'b1, 0); push_exp(1, 32'h31, 1'b1);
    add_flit(2, 32'h32, 1'b1, 0); push_exp(2, 32'h32, 1'b1);
    drive(); #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_regrant: in_ready=%b, required 0010", in_ready);
    end
    run(200, cycles);
    checks++;
    if (sb.size() != 0 || cycles >= 200) begin
      errors++;
      $display("FAIL midrst_drain: left=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_n1_stream();
    flit_t f;
    exp_t  e;
    logic  acc;
    int    cycles;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      f.data = 32'(k); f.last = (k == 8); f.gap = '0;
      s_q.push_back(f);
      e.src = '0; e.data = 32'(k); e.last = (k == 8);
      sb1.push_back(e);
    end
    cycles = 0;
    while ((sb1.size() > 0 || s_q.size() > 0) && cycles < 400) begin
      s_in_valid[0] = (s_q.size() > 0);
      s_in_data[0]  = (s_q.size() > 0) ? s_q[0].data : '0;
      s_in_last[0]  = (s_q.size() > 0) ? s_q[0].last : 1'b0;
      s_out_ready   = 1'($urandom_range(0, 1));
      #1;
      acc = s_in_valid[0] & s_in_ready[0];
      @(posedge clk);
      if (acc) void'(s_q.pop_front());
      @(negedge clk);
      cycles++;
    end
    s_in_valid = '0;
    s_out_ready = 1'b1;
    checks++;
    if (sb1.size() != 0 || s_q.size() != 0) begin
      errors++;
      $display("FAIL n1_drain: left=%0d pending=%0d, required 0 0", sb1.size(), s_q.size());
    end
  endtask

  initial begin
    s_in_valid = '0; s_in_data = '0; s_in_last = '0; s_out_ready = 1'b1;
    for (int i = 0; i < N; i++) gap_cnt[i] = 0;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_mid_reset();
    test_n1_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
